// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming LEGv8 instruction encoder and imem loader
module instr_encoder #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rn,
   input  logic [4:0]        in_rm,
   input  logic [18:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t      state;
   state_t      state_next;
   logic        accept;
   logic        legal;
   logic [31:0] enc_word;

   // start wins over a beat in the same cycle, so it blanks the handshake
   assign in_ready = (state == LOAD) && (count < DEPTH_C) && !start;
   assign accept   = in_valid && in_ready;
   assign legal    = (in_op != 3'd7);
   assign full     = (count == DEPTH_C);
   assign busy     = (state != IDLE);

   // pack the symbolic beat into a machine word; shamt and op2 are always zero
   always_comb begin
      enc_word = 32'd0;
      case (in_op)
         3'd0:    enc_word = {11'b10001011000, in_rm, 6'b000000, in_rn, in_rd};
         3'd1:    enc_word = {11'b11001011000, in_rm, 6'b000000, in_rn, in_rd};
         3'd2:    enc_word = {11'b10001010000, in_rm, 6'b000000, in_rn, in_rd};
         3'd3:    enc_word = {11'b10101010000, in_rm, 6'b000000, in_rn, in_rd};
         3'd4:    enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
         3'd5:    enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
         3'd6:    enc_word = {8'b10110100, in_imm, in_rd};
         default: enc_word = 32'd0;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next state: start (re)opens a session, the last legal beat closes it
   always_comb begin
      state_next = state;
      if (start)
         state_next = LOAD;
      else if (accept && legal && (count == DEPTH_C - 1'b1))
         state_next = FULL;
   end

   // write port, word counter and sticky illegal-op flag
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         count      <= '0;
         err        <= 1'b0;
      end else begin
         imem_we <= accept && legal;
         if (start) begin
            count <= '0;
            err   <= 1'b0;
         end else if (accept) begin
            if (legal) begin
               imem_addr  <= count[ADDR_W-1:0];
               imem_wdata <= enc_word;
               count      <= count + 1'b1;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder
module tb_instr_encoder;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        in_op = 3'd0;
   logic [4:0]        in_rd = 5'd0;
   logic [4:0]        in_rn = 5'd0;
   logic [4:0]        in_rm = 5'd0;
   logic [18:0]       in_imm = 19'd0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              busy;
   logic              err;

   instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .full(full), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  m_count  = 0;
   bit  m_err    = 1'b0;
   bit  m_active = 1'b0;
   bit  mon_en   = 1'b0;
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference encoding built from field weights rather than bit packing
   function automatic logic [31:0] ref_enc(input int unsigned op, rd, rn, rm, imm);
      int unsigned opc;
      case (op)
         0: opc = 'h458;
         1: opc = 'h658;
         2: opc = 'h450;
         3: opc = 'h550;
         4: opc = 'h7C2;
         5: opc = 'h7C0;
         default: opc = 0;
      endcase
      if (op <= 3) return opc * (2**21) + rm * (2**16) + rn * 32 + rd;
      if (op <= 5) return opc * (2**21) + (imm % 512) * 4096 + rn * 32 + rd;
      return 180 * (2**24) + imm * 32 + rd;
   endfunction

   function automatic bit model_ready();
      return m_active && (m_count < DEPTH) && !start;
   endfunction

   // per-cycle comparison of every observable output against the model
   always @(negedge clk) begin
      if (mon_en) begin
         check("in_ready", 32'(in_ready), 32'(model_ready()));
         check("count", 32'(count), 32'(m_count));
         check("full", 32'(full), 32'(m_count == DEPTH));
         check("err", 32'(err), 32'(m_err));
         check("busy", 32'(busy), 32'(m_active));
         check("we", 32'(imem_we), 32'(exp_q.size() != 0));
         if (imem_we && exp_q.size() != 0) begin
            wr_t w;
            w = exp_q.pop_front();
            check("we_addr", 32'(imem_addr), w.a);
            check("we_data", imem_wdata, w.d);
         end
         exp_q.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int unsigned op, rd, rn, rm, imm, input int max_wait, output bit acc);
      bit r;
      in_op = op[2:0]; in_rd = rd[4:0]; in_rn = rn[4:0]; in_rm = rm[4:0]; in_imm = imm[18:0];
      in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < max_wait && !acc; i++) begin
         r = model_ready();
         tick();
         if (r) begin
            acc = 1'b1;
            if (op != 7) begin
               exp_q.push_back('{a: m_count, d: ref_enc(op, rd, rn, rm, imm)});
               m_count++;
            end else begin
               m_err = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_count = 0; m_err = 1'b0; m_active = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_count = 0; m_err = 1'b0; m_active = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      bit acc;
      int unsigned sel;

      repeat (2) tick();
      check("rst_ready", 32'(in_ready), 0);
      check("rst_we", 32'(imem_we), 0);
      check("rst_addr", 32'(imem_addr), 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_count", 32'(count), 0);
      check("rst_full", 32'(full), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);
      reset = 1'b0;
      mon_en = 1'b1;
      tick();

      do_start();
      beat(0, 1, 2, 3, 0, 2, acc);
      check("add_we", 32'(imem_we), 1);
      check("add_addr", 32'(imem_addr), 0);
      check("add_wdata", imem_wdata, 32'h8B030041);
      check("add_count", 32'(count), 1);
      beat(4, 9, 10, 17, 'h010, 2, acc);
      check("ldur_addr", 32'(imem_addr), 1);
      check("ldur_wdata", imem_wdata, 32'hF8410149);
      beat(6, 5, 21, 9, 'h7FFFF, 2, acc);
      check("cbz_wdata", imem_wdata, 32'hB4FFFFE5);
      beat(7, 3, 3, 3, 3, 2, acc);
      check("ill_we", 32'(imem_we), 0);
      check("ill_err", 32'(err), 1);
      check("ill_count", 32'(count), 3);
      beat(1, 0, 0, 0, 0, 2, acc);
      check("sub_addr", 32'(imem_addr), 3);
      check("sub_wdata", imem_wdata, 32'hCB000000);
      check("sub_full", 32'(full), 1);
      beat(0, 1, 1, 1, 0, 3, acc);
      check("full_stall_ready", 32'(in_ready), 0);
      check("full_stall_count", 32'(count), 4);

      do_start();
      for (int i = 0; i < DEPTH; i++) beat(0, i, i + 1, i + 2, 0, 2, acc);
      check("b2b_full", 32'(full), 1);
      check("b2b_count", 32'(count), DEPTH);
      beat(0, 7, 7, 7, 0, 3, acc);
      check("b2b_5th_ready", 32'(in_ready), 0);

      do_start();
      beat(7, 0, 0, 0, 0, 2, acc);
      beat(2, 4, 5, 6, 0, 2, acc);
      beat(3, 7, 8, 9, 0, 2, acc);
      do_start();
      check("restart_count", 32'(count), 0);
      check("restart_err", 32'(err), 0);
      beat(0, 11, 12, 13, 0, 2, acc);
      check("restart_addr", 32'(imem_addr), 0);

      beat(0, 2, 2, 2, 0, 2, acc);
      do_reset();
      check("mid_rst_we", 32'(imem_we), 0);
      check("mid_rst_busy", 32'(busy), 0);

      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 19);
         if (sel == 0 || (sel == 1 && !m_active)) do_start();
         else if (sel == 1) do_reset();
         else if (sel <= 4) tick();
         else beat($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 'h7FFFF), 2, acc);
      end
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
